// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger TX link controller: FSM state codes and the
// cluster-word field that marks an invalid (empty) cluster.
package trigger_pkg;

   localparam logic [2:0] StPwrdn    = 3'd0;
   localparam logic [2:0] StPllRst   = 3'd1;
   localparam logic [2:0] StWaitLock = 3'd2;
   localparam logic [2:0] StTxRst    = 3'd3;
   localparam logic [2:0] StWaitDone = 3'd4;
   localparam logic [2:0] StReady    = 3'd5;
   localparam logic [2:0] StFail     = 3'd6;

   // Address field value the packer uses for "no cluster in this slot".
   localparam logic [1:0]  CLUSTER_INVALID_ADDR = 2'b11;
   localparam int unsigned CLUSTER_ADDR_LSB     = 9;
   localparam int unsigned CLUSTER_ADDR_MSB     = 10;

   function automatic logic cluster_valid(input logic [1:0] addr);
      return addr != CLUSTER_INVALID_ADDR;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs into the clk_40 domain.
module sync2 #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_40,
   input  logic             reset,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   // Metastability stage followed by the stable output stage.
   always_ff @(posedge clk_40) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/trigger_links_ctrl.sv
// Bring-up sequencer for the trigger TX links (PLL power-down/reset, lock wait, TX reset,
// reset-done wait, bounded retries, lock-loss recovery) plus a per-BX cluster monitor.
module trigger_links_ctrl
   import trigger_pkg::*;
#(
   parameter int unsigned NLINKS    = 4,
   parameter int unsigned NCLUSTERS = 8,
   parameter int unsigned CLUSTER_W = 14,
   parameter int unsigned PDCNT     = 96,
   parameter int unsigned RSTCNT    = 128,
   parameter int unsigned TXRSTCNT  = 16,
   parameter int unsigned TIMEOUT   = 4095,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                               clk_40,
   input  logic                               reset,
   input  logic                               restart_i,
   input  logic                               pll_lock_i,
   input  logic [NLINKS-1:0]                  tx_resetdone_i,
   input  logic [NLINKS-1:0]                  link_en_i,
   input  logic [NCLUSTERS*CLUSTER_W-1:0]     clusters_i,
   output logic                               pll_pd_o,
   output logic                               pll_rst_o,
   output logic                               tx_rst_o,
   output logic                               ready_o,
   output logic                               fail_o,
   output logic [2:0]                         state_o,
   output logic [1:0]                         retry_cnt_o,
   output logic [7:0]                         lock_lost_cnt_o,
   output logic [NCLUSTERS-1:0]               valid_clusters_o,
   output logic                               valid_or_o,
   output logic [$clog2(NCLUSTERS+1)-1:0]     valid_count_o,
   output logic [31:0]                        cluster_cnt_o
);

   localparam int unsigned CW         = $clog2(NCLUSTERS+1);
   localparam logic [11:0] PdLast     = 12'(PDCNT - 1);
   localparam logic [11:0] RstLast    = 12'(RSTCNT - 1);
   localparam logic [11:0] TxRstLast  = 12'(TXRSTCNT - 1);
   localparam logic [11:0] TimeoutVal = 12'(TIMEOUT);
   localparam logic [1:0]  RetryLast  = 2'(MAX_RETRY - 1);

   logic              lock_s;
   logic [NLINKS-1:0] done_s;
   logic [2:0]        state_q, state_d;
   logic [11:0]       timer_q, timer_d;
   logic [1:0]        retry_q, retry_d;
   logic [7:0]        lost_q, lost_d;
   logic              pd_q, rst_q, txrst_q, ready_q, fail_q;
   logic              fail_attempt;
   logic [NCLUSTERS-1:0] vflags_d, vflags_q;
   logic              vor_q;
   logic [CW-1:0]     vcount_q;
   logic [31:0]       cluster_cnt_q, cluster_cnt_d;
   logic [32:0]       cnt_sum;
   logic              unused_cluster_bits;

   sync2 #(.Width(1)) u_sync_lock (
      .clk_40 (clk_40),
      .reset  (reset),
      .d_i    (pll_lock_i),
      .q_o    (lock_s)
   );

   sync2 #(.Width(NLINKS)) u_sync_done (
      .clk_40 (clk_40),
      .reset  (reset),
      .d_i    (tx_resetdone_i),
      .q_o    (done_s)
   );

   // Next-state, dwell/timeout timer, retry and lock-loss bookkeeping.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q + 12'd1;
      retry_d      = retry_q;
      lost_d       = lost_q;
      fail_attempt = 1'b0;
      case (state_q)
         StPwrdn:    if (timer_q == PdLast) state_d = StPllRst;
         StPllRst:   if (timer_q == RstLast) state_d = StWaitLock;
         StWaitLock: begin
            if (lock_s) state_d = StTxRst;
            else if (timer_q == TimeoutVal) fail_attempt = 1'b1;
         end
         StTxRst:    if (timer_q == TxRstLast) state_d = StWaitDone;
         StWaitDone: begin
            // Lock loss wins over reset-done: a link that came up on a dying PLL is useless.
            if (!lock_s) fail_attempt = 1'b1;
            else if (&(done_s | ~link_en_i)) begin
               state_d = StReady;
               retry_d = '0;
            end else if (timer_q == TimeoutVal) fail_attempt = 1'b1;
         end
         StReady: begin
            if (!lock_s) begin
               state_d = StPwrdn;
               if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
            end
         end
         StFail:  state_d = StFail;
         default: state_d = StPwrdn;
      endcase
      if (fail_attempt) begin
         if (retry_q == RetryLast) begin
            state_d = StFail;
         end else begin
            retry_d = retry_q + 2'd1;
            state_d = StPwrdn;
         end
      end
      if (state_d != state_q) timer_d = '0;
      if (restart_i) begin
         state_d = StPwrdn;
         retry_d = '0;
         timer_d = '0;
      end
   end

   // FSM state and glitch-free registered control outputs decoded from the next state.
   always_ff @(posedge clk_40) begin
      if (reset) begin
         state_q <= StPwrdn;
         timer_q <= '0;
         retry_q <= '0;
         lost_q  <= '0;
         pd_q    <= 1'b1;
         rst_q   <= 1'b1;
         txrst_q <= 1'b1;
         ready_q <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         lost_q  <= lost_d;
         pd_q    <= (state_d == StPwrdn) || (state_d == StFail);
         rst_q   <= (state_d == StPwrdn) || (state_d == StPllRst) || (state_d == StFail);
         txrst_q <= (state_d != StWaitDone) && (state_d != StReady);
         ready_q <= (state_d == StReady);
         fail_q  <= (state_d == StFail);
      end
   end

   for (genvar k = 0; k < NCLUSTERS; k++) begin : g_valid
      assign vflags_d[k] = cluster_valid(
         clusters_i[k*CLUSTER_W+CLUSTER_ADDR_MSB : k*CLUSTER_W+CLUSTER_ADDR_LSB]);
   end

   // Only the address field matters here; the rest of each word passes to the links untouched.
   assign unused_cluster_bits = ^clusters_i;

   // Saturating accumulation of valid clusters while the links are up.
   always_comb begin
      cnt_sum       = {1'b0, cluster_cnt_q} + 33'(vcount_q);
      cluster_cnt_d = cluster_cnt_q;
      if (ready_q) cluster_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
   end

   // Cluster monitor registers: flags, OR and popcount all share one cycle of latency.
   always_ff @(posedge clk_40) begin
      if (reset) begin
         vflags_q      <= '0;
         vor_q         <= 1'b0;
         vcount_q      <= '0;
         cluster_cnt_q <= '0;
      end else begin
         vflags_q      <= vflags_d;
         vor_q         <= |vflags_d;
         vcount_q      <= CW'($countones(vflags_d));
         cluster_cnt_q <= cluster_cnt_d;
      end
   end

   assign pll_pd_o         = pd_q;
   assign pll_rst_o        = rst_q;
   assign tx_rst_o         = txrst_q;
   assign ready_o          = ready_q;
   assign fail_o           = fail_q;
   assign state_o          = state_q;
   assign retry_cnt_o      = retry_q;
   assign lock_lost_cnt_o  = lost_q;
   assign valid_clusters_o = vflags_q;
   assign valid_or_o       = vor_q;
   assign valid_count_o    = vcount_q;
   assign cluster_cnt_o    = cluster_cnt_q;

endmodule
